coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
- Front-end stage directly upstream of the soda dispenser FSM.
- Conditions the raw coin-slot sensor and classifies the coin by its 2-bit type code.
- Emits exactly one single-cycle coin-detect pulse `c`, with the coin value on `a[7:0]`, per physical coin. This matches what the dispenser samples.
- Rejects invalid coins and glitches, and counts accepted coins.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive sampled-high cycles of coin_sense required to accept a coin. Legal range 2..255.
- VAL0, 8'd5: value in pence for coin_type 2'b00.
- VAL1, 8'd10: value for coin_type 2'b01.
- VAL2, 8'd20: value for coin_type 2'b10. coin_type 2'b11 is always invalid.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = accept new coins. Sampled only in IDLE.
- coin_sense  in  1  raw slot sensor, high while a coin is present. Already synchronised to clk.
- coin_type  in  2  coin classifier code, valid while coin_sense is high.
- c  out  1  coin-accepted pulse, exactly one cycle per accepted coin. Feeds dispenser `c`.
- a  out  8  value of the last accepted coin. Feeds dispenser `a`.
- reject  out  1  one-cycle pulse for a debounced coin with coin_type 2'b11.
- busy  out  1  high in any state other than IDLE.
- coin_count  out  8  number of accepted coins since reset, saturating.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high. When reset is high at a clk edge: state=IDLE, debounce counter=0, latched type=0, c=0, reject=0, a=8'd0, coin_count=8'd0.
  - Reset overrides all other inputs. Reset mid-debounce or mid-emit drops the coin silently; no pulse is produced.
- Outputs:
  - All outputs are registered. c, reject and busy are decoded from the registered state and latched type only.
- State IDLE:
  - If enable=1 and coin_sense=1 at the edge: go to DEBOUNCE, cnt=1, latch coin_type.
  - Otherwise stay in IDLE.
- State DEBOUNCE:
  - coin_sense=0: go to IDLE with no pulse (glitch).
  - coin_sense=1 but coin_type differs from the latched type: stay in DEBOUNCE, cnt=1, relatch coin_type.
  - coin_sense=1, type stable, cnt==DEBOUNCE_CYCLES-1: go to EMIT.
  - Otherwise: cnt=cnt+1.
  - enable is ignored once DEBOUNCE has started.
- State EMIT (exactly one cycle):
  - Latched type valid: c=1; a is loaded with the mapped value at the same edge as entry to EMIT, so a is valid while c=1.
  - Valid coin: coin_count increments, saturating at 255.
  - Latched type 2'b11: reject=1, c=0, and a and coin_count are unchanged.
  - Next state is always RELEASE.
- State RELEASE:
  - Stay while coin_sense=1, so a held coin never produces a second pulse.
  - Go to IDLE at the first edge where coin_sense=0.
- Latency:
  - coin_sense first sampled high at edge k, held with a stable type → c high during the cycle after edge k+DEBOUNCE_CYCLES-1.
  - Default: 4 edges high, then pulse.
- Value hold:
  - a keeps the last accepted value between coins and is never cleared except by reset.
  - Downstream must qualify a with c.
- Back-to-back coins:
  - Minimum spacing is DEBOUNCE_CYCLES+2 cycles: EMIT, one RELEASE cycle with sense low, then a new debounce.
  - Minimum coin_sense low time between coins is 1 cycle.
- Value mapping: 00→VAL0, 01→VAL1, 10→VAL2. No arithmetic is performed on values; summing is the dispenser's job.

Test Plan:
- Reset held for 2 cycles, then released; enable=1, coin_sense=0 for 10 cycles → c=0, reject=0, a=0, coin_count=0, busy=0 throughout.
- coin_type=01, coin_sense high for 6 cycles, sampled high first at edge k → c=1 exactly during the cycle after edge k+3; a=10 from then on; coin_count=1; busy deasserts after sense falls.
- coin_sense high for 2 cycles only (glitch), type 10 → no c, no reject, a unchanged, back to IDLE.
- Coin type 01 then, after a 1-cycle low gap, coin type 10 → two c pulses with a=10 then a=20; a dispenser driven with s=30 asserts d. coin_sense held 50 cycles on a single coin → only one pulse.
- coin_type=11 held 5 cycles → reject=1 for one cycle, c=0, a and coin_count unchanged. Type switching 00→01 at cnt=2 → count restarts; the accepted value is 10.
- Reset asserted during DEBOUNCE (cnt=3) and during EMIT → no pulse, all outputs zero next cycle. enable=0 with a coin present → ignored. 256 valid coins → coin_count stays at 255.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces the coin-slot sensor, classifies the coin
// by type code and emits one single-cycle detect pulse per physical coin.
// Latency: coin_sense high at edge k, stable type -> c high after edge k+DEBOUNCE_CYCLES-1.
// Backpressure: none; a coin held in the slot parks the FSM in RELEASE until it leaves.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   enable       accept new coins (sampled only while idle)
//   coin_sense   slot sensor, already synchronous to clk
//   coin_type    classifier code, valid while coin_sense is high
//   c            one-cycle accepted-coin pulse
//   a            value of the last accepted coin (held between coins)
//   reject       one-cycle pulse for a debounced coin of type 2'b11
//   busy         high whenever the FSM is not idle
//   coin_count   accepted coins since reset, saturating at 255
module coin_acceptor #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [7:0] VAL0            = 8'd5,
  parameter logic [7:0] VAL1            = 8'd10,
  parameter logic [7:0] VAL2            = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       coin_sense,
  input  logic [1:0] coin_type,
  output logic       c,
  output logic [7:0] a,
  output logic       reject,
  output logic       busy,
  output logic [7:0] coin_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] TYPE_BAD = 2'b11;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] ltype, ltype_nxt;
  logic       load;

  function automatic logic [7:0] coin_value(input logic [1:0] t);
    case (t)
      2'b00:   coin_value = VAL0;
      2'b01:   coin_value = VAL1;
      2'b10:   coin_value = VAL2;
      default: coin_value = 8'd0;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ltype_nxt = ltype;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && coin_sense) begin
          state_nxt = DEBOUNCE;
          cnt_nxt   = 8'd1;
          ltype_nxt = coin_type;
        end
      end
      DEBOUNCE: begin
        if (!coin_sense) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (coin_type != ltype) begin
          // Classifier changed its mind: restart the stability window.
          cnt_nxt   = 8'd1;
          ltype_nxt = coin_type;
        end else if (cnt == CNT_LAST) begin
          state_nxt = EMIT;
          // Load a and the counter on the EMIT entry edge so a is valid with c.
          load      = (ltype != TYPE_BAD);
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      EMIT: begin
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!coin_sense) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      ltype      <= 2'b00;
      a          <= 8'd0;
      coin_count <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ltype <= ltype_nxt;
      if (load) begin
        a <= coin_value(ltype);
        if (coin_count != 8'hFF) coin_count <= coin_count + 8'd1;
      end
    end
  end

  // Pulses are pure decodes of registered state and latched type.
  assign c      = (state == EMIT) && (ltype != TYPE_BAD);
  assign reject = (state == EMIT) && (ltype == TYPE_BAD);
  assign busy   = (state != IDLE);

endmodule
